// File: rtl/real_mac_accum.sv
// rtl/real_mac_accum.sv - fixed-point MAC emitting one rescaled block sum every N accepted pairs.
// Optional REAL_MAC_SATURATE_EN clamps out-of-range results instead of wrapping them.
module real_mac_accum #(
  parameter int WIDTH   = 25,
  parameter int EXP_A   = -16,
  parameter int EXP_B   = -16,
  parameter int EXP_OUT = -16,
  parameter int ACC_W   = 56,
  parameter int N       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_ovf
);

  localparam int SHIFT  = EXP_A + EXP_B - EXP_OUT;
  localparam int SH_POS = (SHIFT > 0) ? SHIFT : 0;
  localparam int SH_NEG = (SHIFT < 0) ? -SHIFT : 0;
  localparam int RS_W   = ACC_W + SH_POS;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ACC, DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic signed [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [WIDTH-1:0]   r_data;
  logic                      r_ovf;

  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_acc_nxt;
  logic signed [RS_W-1:0]    w_ext;
  logic signed [RS_W-1:0]    w_scaled;
  logic                      w_fits;
  logic signed [WIDTH-1:0]   w_data;
  logic                      w_accept;
  logic                      w_last;

  assign w_prod     = in_a * in_b;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_acc_nxt  = r_acc + w_prod_ext;

  // One of the two shift amounts is always zero, so this covers both rescale directions.
  assign w_ext    = RS_W'(w_acc_nxt);
  assign w_scaled = (w_ext <<< SH_POS) >>> SH_NEG;

  // Fits iff every bit from the result's sign position upward agrees.
  assign w_fits = (&w_scaled[RS_W-1:WIDTH-1]) | ~(|w_scaled[RS_W-1:WIDTH-1]);

`ifdef REAL_MAC_SATURATE_EN
  assign w_data = w_fits ? w_scaled[WIDTH-1:0]
                : (w_scaled[RS_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign w_data = w_scaled[WIDTH-1:0];
`endif

  assign w_accept = (r_state == ACC) && in_valid;
  assign w_last   = (r_cnt == CNT_W'(N - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ACC:     if (in_valid && w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = ACC;
      default: w_next = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_acc <= w_acc_nxt;
        if (w_last) begin
          r_data <= w_data;
          r_ovf  <= ~w_fits;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (r_state == DONE && out_ready) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end
  end

  assign in_ready  = (r_state == ACC) && !rst;
  assign out_valid = (r_state == DONE);
  assign out_data  = r_data;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_real_mac_accum.sv
// tb/tb_real_mac_accum.sv - table, hand-sequence and randomized checks of real_mac_accum.
// Honours REAL_MAC_SATURATE_EN the same way as the design.
module tb_real_mac_accum;

`ifdef REAL_MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Three instances: default scale N=4, right shift by 24 N=4, left shift by 4 N=1.
  localparam int SH [3] = '{-16, -24, 4};
  localparam int NN [3] = '{4, 4, 1};

  logic clk;
  logic rst;
  logic                in_valid_v  [3];
  logic                in_ready_v  [3];
  logic signed [24:0]  a_v         [3];
  logic signed [24:0]  b_v         [3];
  logic                out_valid_v [3];
  logic                out_ready_v [3];
  logic signed [24:0]  data_v      [3];
  logic                ovf_v       [3];

  int checks   = 0;
  int failures = 0;

  real_mac_accum #(.N(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_a(a_v[0]), .in_b(b_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_data(data_v[0]), .out_ovf(ovf_v[0]));

  real_mac_accum #(.N(4), .EXP_OUT(-8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_a(a_v[1]), .in_b(b_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_data(data_v[1]), .out_ovf(ovf_v[1]));

  real_mac_accum #(.N(1), .EXP_OUT(-36)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_a(a_v[2]), .in_b(b_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .out_data(data_v[2]), .out_ovf(ovf_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Real-valued rule: rescale the exact block sum, then range-check and clamp or wrap to 25 bits.
  function automatic void model(input longint sum, input int s, output longint d, output bit o);
    longint r;
    longint m;
    r = (s < 0) ? (sum >>> (-s)) : (sum <<< s);
    o = (r > 64'sd16777215) || (r < -64'sd16777216);
    if (o && SAT) begin
      d = (r < 0) ? -64'sd16777216 : 64'sd16777215;
    end else begin
      m = r & 64'h1FF_FFFF;
      d = (m >= 64'sd16777216) ? (m - 64'sd33554432) : m;
    end
  endfunction

  task automatic feed(input int k, input bit v, input logic signed [24:0] a, input logic signed [24:0] b);
    chk("in_ready_acc", in_ready_v[k], 1);
    in_valid_v[k] = v;
    a_v[k] = a;
    b_v[k] = b;
    @(negedge clk);
    in_valid_v[k] = 1'b0;
  endtask

  task automatic release_out(input int k);
    out_ready_v[k] = 1'b1;
    @(negedge clk);
    out_ready_v[k] = 1'b0;
    chk("rel_out_valid", out_valid_v[k], 0);
    chk("rel_in_ready", in_ready_v[k], 1);
  endtask

  task automatic block_const(input string nm, input int k, input logic signed [24:0] a,
                             input logic signed [24:0] b, input longint ed, input bit eo);
    for (int i = 0; i < NN[k]; i++) begin
      chk({nm, "_early_valid"}, out_valid_v[k], 0);
      feed(k, 1'b1, a, b);
    end
    chk({nm, "_latency"}, out_valid_v[k], 1);
    chk({nm, "_done_ready"}, in_ready_v[k], 0);
    chk({nm, "_data"}, data_v[k], ed);
    chk({nm, "_ovf"}, ovf_v[k], eo);
    release_out(k);
  endtask

  task automatic block_rand(input int k);
    longint sum;
    longint ed;
    bit eo;
    int cnt;
    int guard;
    bit v;
    logic signed [24:0] a;
    logic signed [24:0] b;
    sum = 0;
    cnt = 0;
    guard = 0;
    while (cnt < NN[k] && guard < 100) begin
      v = ($urandom_range(0, 2) != 0);
      a = 25'($urandom);
      b = 25'($urandom);
      if ($urandom_range(0, 1) == 1) a = a >>> 9;
      if ($urandom_range(0, 1) == 1) b = b >>> 9;
      chk("rnd_early_valid", out_valid_v[k], 0);
      feed(k, v, a, b);
      if (v) begin
        sum += longint'(a) * longint'(b);
        cnt++;
      end
      guard++;
    end
    model(sum, SH[k], ed, eo);
    chk("rnd_latency", out_valid_v[k], 1);
    for (int h = $urandom_range(0, 3); h > 0; h--) begin
      @(negedge clk);
      chk("rnd_hold_valid", out_valid_v[k], 1);
    end
    chk("rnd_data", data_v[k], ed);
    chk("rnd_ovf", ovf_v[k], eo);
    release_out(k);
  endtask

  typedef struct {
    int                 k;
    logic signed [24:0] a;
    logic signed [24:0] b;
    longint             d;
    bit                 o;
  } vec_t;

  vec_t tbl [14];
  bit   pat [7];

  initial begin
    tbl[0]  = '{0,  25'sd6553600,   25'sd6553600, SAT ? 64'sd16777215 : 64'sd4194304, 1'b1};
    tbl[1]  = '{0, -25'sd65536,     25'sd65536,   -64'sd262144, 1'b0};
    tbl[2]  = '{0, -25'sd6553600,   25'sd6553600, SAT ? -64'sd16777216 : -64'sd4194304, 1'b1};
    tbl[3]  = '{0,  25'sd16777215,  25'sd16384,   64'sd16777215, 1'b0};
    tbl[4]  = '{0, -25'sd16777216,  25'sd16384,   -64'sd16777216, 1'b0};
    tbl[5]  = '{0, -25'sd16777216, -25'sd16384,   SAT ? 64'sd16777215 : -64'sd16777216, 1'b1};
    tbl[6]  = '{0,  25'sd0,        -25'sd16777216, 64'sd0, 1'b0};
    tbl[7]  = '{1, -25'sd1,         25'sd1,       -64'sd1, 1'b0};
    tbl[8]  = '{1,  25'sd65536,     25'sd65536,   64'sd1024, 1'b0};
    tbl[9]  = '{1, -25'sd65536,     25'sd65536,   -64'sd1024, 1'b0};
    tbl[10] = '{2,  25'sd3,         25'sd5,       64'sd240, 1'b0};
    tbl[11] = '{2, -25'sd16777216,  25'sd1,       SAT ? -64'sd16777216 : 64'sd0, 1'b1};
    tbl[12] = '{2,  25'sd1048575,   25'sd1,       64'sd16777200, 1'b0};
    tbl[13] = '{2,  25'sd1048576,   25'sd1,       SAT ? 64'sd16777215 : -64'sd16777216, 1'b1};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_v[k]  = 1'b0;
      a_v[k]         = '0;
      b_v[k]         = '0;
      out_ready_v[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready_v[0], 0);
    chk("rst_out_valid", out_valid_v[0], 0);
    chk("rst_out_data", data_v[0], 0);
    chk("rst_out_ovf", ovf_v[0], 0);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("post_rst_in_ready", in_ready_v[k], 1);
    @(negedge clk);

    // Basic 1.0 x 2.0 block, then hold the result under backpressure.
    for (int i = 0; i < 4; i++) begin
      chk("basic_early_valid", out_valid_v[0], 0);
      feed(0, 1'b1, 25'sd65536, 25'sd131072);
    end
    chk("basic_latency", out_valid_v[0], 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready_v[0], 0);
      chk("bp_out_valid", out_valid_v[0], 1);
      chk("bp_out_data", data_v[0], 524288);
      chk("bp_out_ovf", ovf_v[0], 0);
      @(negedge clk);
    end
    release_out(0);
    block_const("after_bp", 0, 25'sd65536, 25'sd65536, 64'sd262144, 1'b0);

    foreach (tbl[i]) block_const($sformatf("tbl%0d", i), tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].o);

    // Bubbles: only the four valid beats count.
    for (int i = 0; i < 7; i++) begin
      chk("bub_early_valid", out_valid_v[0], 0);
      feed(0, pat[i], 25'sd65536, 25'sd65536);
    end
    chk("bub_latency", out_valid_v[0], 1);
    chk("bub_data", data_v[0], 262144);
    chk("bub_ovf", ovf_v[0], 0);
    release_out(0);

    // Reset mid-block discards the partial sum.
    feed(0, 1'b1, 25'sd65536, 25'sd65536);
    feed(0, 1'b1, 25'sd65536, 25'sd65536);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_after_ready", in_ready_v[0], 1);
    chk("midrst_after_valid", out_valid_v[0], 0);
    block_const("midrst_blk", 0, 25'sd65536, 25'sd65536, 64'sd262144, 1'b0);

    for (int r = 0; r < 30; r++) block_rand(r % 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
